// File: rtl/mem_access_ctrl_if.sv
// Memory-side request/acknowledge bus for the MEM-stage access controller.
// master: the controller (drives request, address, data, byte enables).
// slave: the data memory (drives the acknowledge pulse and read data).
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory.
// Issues one registered req/ack transaction per load/store, stalls the front of the pipeline
// and bubbles MEM/WB while the access is outstanding, and returns load data as ReadDataM.
// Optional build macro: MEM_TIMEOUT_EN adds a REQ-state watchdog that aborts the access
// after TIMEOUT_CYCLES cycles without an acknowledge and pulses mem_err.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  mem_access_ctrl_if.master bus,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        BubbleW,
  output logic        mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;

  logic access;
  logic ack_take;
  logic timeout_hit;
  logic stall;

  assign access   = MemReadM | MemWriteM;
  // Acknowledges are only meaningful while a request is outstanding.
  assign ack_take = (state_q == REQ) & bus.mem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Ack on the terminal-count edge takes priority over the abort.
  assign timeout_hit = (state_q == REQ) & ~bus.mem_ack & (cnt_q == TermCnt);

  // Watchdog counter: cleared while idle, counts REQ cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == REQ) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Error flag is high exactly for the DONE cycle that follows an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign mem_err = err_q;
`else
  logic [CNT_W-1:0] unused_term_cnt;

  assign unused_term_cnt = CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout_hit     = 1'b0;
  assign mem_err         = 1'b0;
`endif

  // Next-state logic; DONE always returns to IDLE so an instruction is never re-issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access) state_d = REQ;
      REQ:  if (ack_take || timeout_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request and bus latches: captured on issue, held stable until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if ((state_q == IDLE) && access) begin
      req_q   <= 1'b1;
      // Read and write together is treated as a store.
      we_q    <= MemWriteM;
      addr_q  <= ALUResultM;
      wdata_q <= WriteDataM;
      be_q    <= ByteEnM;
    end else if (ack_take || timeout_hit) begin
      req_q   <= 1'b0;
    end
  end

  // Load data capture; stores and aborted accesses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ack_take) begin
      rdata_q <= we_q ? 32'd0 : bus.mem_rdata;
    end else if (timeout_hit) begin
      rdata_q <= '0;
    end
  end

  // Stall while an access is being launched or is outstanding; DONE lets the pipeline move.
  always_comb begin
    stall = ((state_q == IDLE) & access) | (state_q == REQ);
  end

  assign StallF    = stall;
  assign StallD    = stall;
  assign StallE    = stall;
  assign StallM    = stall;
  assign BubbleW   = stall;
  assign ReadDataM = rdata_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural memory responder acknowledges in a
// chosen REQ cycle, expected ReadDataM values go into a scoreboard queue at issue time and are
// compared when the access reaches DONE.
module tb_mem_access_ctrl;

  localparam int unsigned TO    = 8;
  localparam int          BOUND = 200;

  logic        clk;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  ByteEnM;
  logic [31:0] ReadDataM;
  logic        StallF, StallD, StallE, StallM, BubbleW, mem_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .ByteEnM   (ByteEnM),
    .bus       (bus.master),
    .ReadDataM (ReadDataM),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .StallM    (StallM),
    .BubbleW   (BubbleW),
    .mem_err   (mem_err)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access; k = REQ cycle carrying the ack (0 = never ack, rely on timeout).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int k,
                           input logic [31:0] rdata);
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    int          stall_cnt;
    int          bub_cnt;
    int          req_cyc;
    int          exp_stall;
    bit          done;
    exp_rd    = (wr || k == 0) ? 32'd0 : rdata;
    exp_stall = (k == 0) ? int'(TO) + 1 : k + 1;
    sb_q.push_back(exp_rd);
    stall_cnt = 0;
    bub_cnt   = 0;
    req_cyc   = 0;
    done      = 1'b0;
    @(negedge clk);
    MemReadM   = rd;
    MemWriteM  = wr;
    ALUResultM = addr;
    WriteDataM = wdata;
    ByteEnM    = be;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < BOUND; c++) begin
      #1;
      if (!StallM) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (BubbleW && StallF && StallD && StallE) bub_cnt++;
      if (bus.mem_req) begin
        req_cyc++;
        if (req_cyc == 1 || req_cyc == k) begin
          check("bus_addr", bus.mem_addr, addr);
          check("bus_wdata", bus.mem_wdata, wdata);
          check("bus_be", {28'd0, bus.mem_be}, {28'd0, be});
          check("bus_we", {31'd0, bus.mem_we}, {31'd0, wr});
        end
        if (req_cyc == k) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
    end
    if (!done) check("access_complete", 32'd0, 32'd1);
    got_rd = sb_q.pop_front();
    check("done_rdata", ReadDataM, got_rd);
    check("done_req", {31'd0, bus.mem_req}, 32'd0);
    check("stall_cycles", stall_cnt, exp_stall);
    check("bubble_cycles", bub_cnt, exp_stall);
    check("req_cycles", req_cyc, (k == 0) ? int'(TO) : k);
`ifdef MEM_TIMEOUT_EN
    check("done_err", {31'd0, mem_err}, {31'd0, (k == 0)});
`else
    check("done_err", {31'd0, mem_err}, 32'd0);
`endif
    // Stray ack while in DONE, with the instruction leaving MEM.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("idle_rdata_hold", ReadDataM, got_rd);
    check("idle_stall", {31'd0, StallM}, 32'd0);
    check("idle_req", {31'd0, bus.mem_req}, 32'd0);
    check("idle_err", {31'd0, mem_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    ALUResultM    = '0;
    WriteDataM    = '0;
    ByteEnM       = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_stall", {31'd0, StallM}, 32'd0);

    // Load, ack in 3rd REQ cycle.
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 32'hCAFE_F00D);
    // Store, ack in 1st REQ cycle; read data must not leak through.
    do_access(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'b0011, 1, 32'h5555_AAAA);
    // Back-to-back loads.
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 32'h0101_0101);
    do_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 1, 32'h2020_2020);
    // Read and write together behaves as a store.
    do_access(1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_5A5A, 4'b1100, 2, 32'h7777_7777);
    // Load leaving nonzero data for the following checks.
    do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 5, 32'h1357_9BDF);

    // Stray ack in IDLE.
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("stray_idle_rdata", ReadDataM, 32'h1357_9BDF);
    check("stray_idle_req", {31'd0, bus.mem_req}, 32'd0);
    check("stray_idle_stall", {31'd0, StallM}, 32'd0);

    // Reset mid-REQ, with an ack coincident with reset.
    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h0000_0800;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, StallM}, 32'd1);
    MemReadM = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst2_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst2_addr", bus.mem_addr, 32'd0);
    check("rst2_wdata", bus.mem_wdata, 32'd0);
    check("rst2_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst2_rdata", ReadDataM, 32'd0);
    check("rst2_err", {31'd0, mem_err}, 32'd0);
    check("rst2_stall", {31'd0, StallM}, 32'd0);
    // Late ack after reset.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD1_BAD1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("late_ack_rdata", ReadDataM, 32'd0);
    check("late_ack_req", {31'd0, bus.mem_req}, 32'd0);

    // Pipeline resumes normally after reset.
    do_access(1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF, 2, 32'h0BAD_CAFE);

`ifdef MEM_TIMEOUT_EN
    // No ack: watchdog aborts after TO REQ cycles, then a normal access follows.
    do_access(1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF, 0, 32'h0);
    do_access(1'b1, 1'b0, 32'h0000_0A04, 32'h0, 4'hF, int'(TO), 32'h4242_4242);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
